window_motor_scheduler: RTL and testbench

//  Shares the single window motor driver among N_WIN windows of the thermostat house system.
//  - Collects per-window open/close requests.
//  - Picks one eligible window round-robin and issues a start/done handshake to the driver.
//  - Enforces a settle dead-time between moves and a timeout watchdog.
//  - Tracks the open/closed state of every window and drives the 2-bit status LED.

---
 rtl/thermo_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/window_motor_scheduler.sv | 156 +++++++++++++++
 tb/tb_window_motor_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermostat house window control.
package thermo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_MOVE,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] LED_IDLE  = 2'b00;
  localparam logic [1:0] LED_OPEN  = 2'b01;
  localparam logic [1:0] LED_CLOSE = 2'b10;
  localparam logic [1:0] LED_FAULT = 2'b11;

  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_WIN = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_WIN-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] idx;

  // Scan from the far end back toward ptr so the nearest eligible index wins.
  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = int'(N_WIN) - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % int'(N_WIN));
      if (eligible[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/window_motor_scheduler.sv
// Shares one window motor driver among N_WIN windows: round-robin grants,
// settle dead-time, timeout watchdog and per-window open/closed tracking.
module window_motor_scheduler
  import thermo_pkg::*;
#(
  parameter int unsigned N_WIN       = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_WIN-1:0] open_req,
  input  logic [N_WIN-1:0] close_req,
  input  logic             fault_clr,
  output logic             drv_start,
  output logic             drv_dir,
  output logic [ID_W-1:0]  drv_id,
  input  logic             drv_done,
  output logic [N_WIN-1:0] win_state,
  output logic             busy,
  output logic             fault,
  output logic [ID_W-1:0]  fault_id,
  output logic [1:0]       led
);

  localparam int unsigned MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [ID_W-1:0]  ptr_q, ptr_n;

  logic             drv_start_n, drv_dir_n, busy_n, fault_n;
  logic [ID_W-1:0]  drv_id_n, fault_id_n;
  logic [N_WIN-1:0] win_state_n;
  logic [1:0]       led_n;

  logic [N_WIN-1:0] need_close, need_open, eligible;
  logic             any;
  logic [ID_W-1:0]  grant_id;

  // Close wins over open; already-satisfied requests drop out.
  assign need_close = close_req & win_state;
  assign need_open  = open_req & ~win_state & ~close_req;
  assign eligible   = need_close | need_open;

  // One counter serves both the move watchdog and the settle dead-time.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  rr_arbiter #(
    .N_WIN (N_WIN),
    .ID_W  (ID_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (any),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      drv_start <= 1'b0;
      drv_dir   <= 1'b0;
      drv_id    <= '0;
      win_state <= '0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      fault_id  <= '0;
      led       <= LED_IDLE;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      ptr_q     <= ptr_n;
      drv_start <= drv_start_n;
      drv_dir   <= drv_dir_n;
      drv_id    <= drv_id_n;
      win_state <= win_state_n;
      busy      <= busy_n;
      fault     <= fault_n;
      fault_id  <= fault_id_n;
      led       <= led_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    ptr_n       = ptr_q;
    drv_dir_n   = drv_dir;
    drv_id_n    = drv_id;
    win_state_n = win_state;
    fault_id_n  = fault_id;
    drv_start_n = 1'b0;
    busy_n      = 1'b0;
    fault_n     = 1'b0;
    led_n       = LED_IDLE;

    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        if (enable && any) begin
          state_n   = ST_START;
          drv_id_n  = grant_id;
          drv_dir_n = need_close[grant_id] ? DIR_CLOSE : DIR_OPEN;
          ptr_n     = (grant_id == ID_W'(N_WIN - 1)) ? '0 : grant_id + ID_W'(1);
        end
      end
      ST_START: begin
        cnt_n   = '0;
        state_n = ST_MOVE;
      end
      ST_MOVE: begin
        // A completion on the last watchdog cycle still counts as success.
        if (drv_done) begin
          win_state_n[drv_id] = drv_dir;
          cnt_n               = '0;
          state_n             = ST_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          fault_id_n = drv_id;
          cnt_n      = '0;
          state_n    = ST_FAULT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (fault_clr) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Registered outputs follow the next state so they change with it.
    drv_start_n = (state_n == ST_START);
    busy_n      = (state_n != ST_IDLE);
    fault_n     = (state_n == ST_FAULT);
    case (state_n)
      ST_START, ST_MOVE: led_n = drv_dir_n ? LED_OPEN : LED_CLOSE;
      ST_FAULT:          led_n = LED_FAULT;
      default:           led_n = LED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_motor_scheduler.sv
// Directed self-checking bench for window_motor_scheduler (default parameters).
module tb_window_motor_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] open_req;
  logic [7:0] close_req;
  logic       fault_clr;
  logic       drv_start;
  logic       drv_dir;
  logic [2:0] drv_id;
  logic       drv_done;
  logic [7:0] win_state;
  logic       busy;
  logic       fault;
  logic [2:0] fault_id;
  logic [1:0] led;

  int n_cmp = 0;
  int n_bad = 0;

  window_motor_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .open_req  (open_req),
    .close_req (close_req),
    .fault_clr (fault_clr),
    .drv_start (drv_start),
    .drv_dir   (drv_dir),
    .drv_id    (drv_id),
    .drv_done  (drv_done),
    .win_state (win_state),
    .busy      (busy),
    .fault     (fault),
    .fault_id  (fault_id),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    open_req  = '0;
    close_req = '0;
    drv_done  = 1'b0;
    fault_clr = 1'b0;
    enable    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for the next drv_start pulse.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (drv_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Driver answers lat clocks after drv_start, then the 4 settle clocks elapse.
  task automatic finish_move(input int lat);
    repeat (lat - 1) tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; open_req = 8'hFF; close_req = 8'h00;
    fault_clr = 1'b0; drv_done = 1'b0;
    tick();
    tick();
    n_cmp++; if (drv_start !== 1'b0) begin n_bad++; $display("FAIL rst_drv_start: got %b expected 0", drv_start); end
    n_cmp++; if (drv_dir !== 1'b0) begin n_bad++; $display("FAIL rst_drv_dir: got %b expected 0", drv_dir); end
    n_cmp++; if (drv_id !== 3'd0) begin n_bad++; $display("FAIL rst_drv_id: got %0d expected 0", drv_id); end
    n_cmp++; if (win_state !== 8'h00) begin n_bad++; $display("FAIL rst_win_state: got %h expected 00", win_state); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b expected 0", fault); end
    n_cmp++; if (fault_id !== 3'd0) begin n_bad++; $display("FAIL rst_fault_id: got %0d expected 0", fault_id); end
    n_cmp++; if (led !== 2'b00) begin n_bad++; $display("FAIL rst_led: got %b expected 00", led); end
    open_req = 8'h00;
    rst      = 1'b0;
    tick();
    n_cmp++; if (drv_start !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got start=%b busy=%b expected 0/0", drv_start, busy); end
  endtask

  task automatic test_single_open();
    bit ok;
    do_reset();
    open_req = 8'h04;
    wait_start(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL open_start: got no drv_start expected pulse"); end
    n_cmp++; if (drv_id !== 3'd2 || drv_dir !== 1'b1) begin n_bad++; $display("FAIL open_grant: got id=%0d dir=%b expected 2/1", drv_id, drv_dir); end
    n_cmp++; if (led !== 2'b01 || busy !== 1'b1) begin n_bad++; $display("FAIL open_led: got led=%b busy=%b expected 01/1", led, busy); end
    tick();
    n_cmp++; if (drv_start !== 1'b0) begin n_bad++; $display("FAIL open_start_pulse: got %b expected 0", drv_start); end
    repeat (3) tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    open_req = 8'h00;
    n_cmp++; if (win_state !== 8'h04) begin n_bad++; $display("FAIL open_win_state: got %h expected 04", win_state); end
    n_cmp++; if (led !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL open_settle: got led=%b busy=%b expected 00/1", led, busy); end
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL open_settle_len: got busy=%b expected 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL open_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    open_req = 8'h81; close_req = 8'h00;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd0 || drv_dir !== 1'b1) begin n_bad++; $display("FAIL rr_first: got ok=%b id=%0d dir=%b expected 1/0/1", ok, drv_id, drv_dir); end
    finish_move(3);
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd7 || drv_dir !== 1'b1) begin n_bad++; $display("FAIL rr_second: got ok=%b id=%0d dir=%b expected 1/7/1", ok, drv_id, drv_dir); end
    finish_move(3);
    n_cmp++; if (win_state !== 8'h81) begin n_bad++; $display("FAIL rr_state_open: got %h expected 81", win_state); end
    close_req = 8'h81;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd0 || drv_dir !== 1'b0 || led !== 2'b10) begin n_bad++; $display("FAIL rr_wrap: got ok=%b id=%0d dir=%b led=%b expected 1/0/0/10", ok, drv_id, drv_dir, led); end
    finish_move(2);
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd7 || drv_dir !== 1'b0) begin n_bad++; $display("FAIL rr_fourth: got ok=%b id=%0d dir=%b expected 1/7/0", ok, drv_id, drv_dir); end
    finish_move(2);
    n_cmp++; if (win_state !== 8'h00) begin n_bad++; $display("FAIL rr_state_closed: got %h expected 00", win_state); end
    open_req = 8'h00; close_req = 8'h00;
  endtask

  task automatic test_conflict();
    bit ok;
    open_req = 8'h08;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd3 || drv_dir !== 1'b1) begin n_bad++; $display("FAIL conf_open: got ok=%b id=%0d dir=%b expected 1/3/1", ok, drv_id, drv_dir); end
    finish_move(2);
    close_req = 8'h08;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd3 || drv_dir !== 1'b0 || led !== 2'b10) begin n_bad++; $display("FAIL conf_close: got ok=%b id=%0d dir=%b led=%b expected 1/3/0/10", ok, drv_id, drv_dir, led); end
    finish_move(2);
    n_cmp++; if (win_state !== 8'h00) begin n_bad++; $display("FAIL conf_state: got %h expected 00", win_state); end
    open_req = 8'h00; close_req = 8'h00;
  endtask

  task automatic test_timeout();
    bit ok;
    bit saw;
    open_req = 8'h20;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd5) begin n_bad++; $display("FAIL tmo_start: got ok=%b id=%0d expected 1/5", ok, drv_id); end
    repeat (32) tick();
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got fault=%b expected 0", fault); end
    tick();
    n_cmp++; if (fault !== 1'b1 || fault_id !== 3'd5 || led !== 2'b11) begin n_bad++; $display("FAIL tmo_fault: got fault=%b id=%0d led=%b expected 1/5/11", fault, fault_id, led); end
    n_cmp++; if (win_state !== 8'h00 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_state: got win=%h busy=%b expected 00/1", win_state, busy); end
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (drv_start !== 1'b0) saw = 1'b1;
    end
    n_cmp++; if (saw || fault !== 1'b1) begin n_bad++; $display("FAIL tmo_hold: got start_seen=%b fault=%b expected 0/1", saw, fault); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_cmp++; if (fault !== 1'b0 || led !== 2'b00 || busy !== 1'b0 || fault_id !== 3'd5) begin n_bad++; $display("FAIL tmo_clear: got fault=%b led=%b busy=%b id=%0d expected 0/00/0/5", fault, led, busy, fault_id); end
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd5 || drv_dir !== 1'b1) begin n_bad++; $display("FAIL tmo_regrant: got ok=%b id=%0d dir=%b expected 1/5/1", ok, drv_id, drv_dir); end
    finish_move(3);
    n_cmp++; if (win_state !== 8'h20) begin n_bad++; $display("FAIL tmo_done_state: got %h expected 20", win_state); end
    open_req = 8'h00;
  endtask

  task automatic test_enable_rst();
    bit ok;
    bit saw;
    open_req = 8'h02;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd1) begin n_bad++; $display("FAIL en_start: got ok=%b id=%0d expected 1/1", ok, drv_id); end
    enable = 1'b0;
    finish_move(2);
    n_cmp++; if (win_state !== 8'h22 || busy !== 1'b0) begin n_bad++; $display("FAIL en_complete: got win=%h busy=%b expected 22/0", win_state, busy); end
    open_req = 8'h42;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (drv_start !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    n_cmp++; if (saw) begin n_bad++; $display("FAIL en_no_grant: got activity=%b expected 0", saw); end
    enable = 1'b1;
    wait_start(ok);
    n_cmp++; if (!ok || drv_id !== 3'd6) begin n_bad++; $display("FAIL en_resume: got ok=%b id=%0d expected 1/6", ok, drv_id); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (drv_start !== 1'b0 || drv_dir !== 1'b0 || drv_id !== 3'd0) begin n_bad++; $display("FAIL mid_rst_drv: got start=%b dir=%b id=%0d expected 0/0/0", drv_start, drv_dir, drv_id); end
    n_cmp++; if (win_state !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_state: got win=%h busy=%b expected 00/0", win_state, busy); end
    n_cmp++; if (fault !== 1'b0 || fault_id !== 3'd0 || led !== 2'b00) begin n_bad++; $display("FAIL mid_rst_fault: got fault=%b id=%0d led=%b expected 0/0/00", fault, fault_id, led); end
    rst = 1'b0;
    open_req = 8'h00;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; open_req = '0; close_req = '0;
    fault_clr = 1'b0; drv_done = 1'b0;
    test_reset();
    test_single_open();
    test_round_robin();
    test_conflict();
    test_timeout();
    test_enable_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
